comparator_sequencer: RTL and testbench

COMPARATOR_SEQUENCER -- requirements
Module: comparator_sequencer

---
 rtl/comparator_sequencer.sv | 141 ++++++++++++++
 tb/tb_comparator_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_sequencer.sv
// Arbitrates two requesters onto one serialized comparator: clears it, waits
// LATENCY cycles, captures the result flags and holds them until consumed.
module comparator_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             cmp_reset,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_gt,
  output logic             busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } flags_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  flags_t           flags_q, flags_d;
  logic             gnt0, gnt1;

  // On a tie the requester that was not served last wins; a lone requester always wins.
  assign gnt0 = req0_valid && (!req1_valid || last_q);
  assign gnt1 = req1_valid && (!req0_valid || !last_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    flags_d    = flags_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = CLEAR;
        end else if (gnt1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Flags are passed through untouched, even if not one-hot.
        if (cnt_q == CNT_LAST) begin
          flags_d = '{lt: cmp_lt, eq: cmp_eq, gt: cmp_gt};
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmp_reset = (state_q == IDLE) || (state_q == CLEAR);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign cmp_a     = a_q;
  assign cmp_b     = b_q;
  assign res_id    = id_q;
  assign res_lt    = flags_q.lt;
  assign res_eq    = flags_q.eq;
  assign res_gt    = flags_q.gt;

endmodule

// File: tb/tb_comparator_sequencer.sv
// Bench for comparator_sequencer: behavioural comparator with latency, arbitration
// and timing reference model, directed plus randomized scenarios.
module tb_comparator_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned LAT   = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready;
  logic             cmp_reset;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             cmp_lt, cmp_eq, cmp_gt;
  logic             res_valid, res_ready;
  logic             res_id, res_lt, res_eq, res_gt;
  logic             busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   model_last;
  bit   force_en = 1'b0;
  logic [2:0] force_flags = 3'b000;
  int unsigned ccnt;

  comparator_sequencer #(.WIDTH(WIDTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .cmp_reset(cmp_reset), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Serialized comparator: flags are only meaningful LAT clocks after cmp_reset drops.
  always @(posedge clk or posedge reset) begin
    if (reset)           ccnt <= 0;
    else if (cmp_reset)  ccnt <= 0;
    else if (ccnt < 1000) ccnt <= ccnt + 1;
  end

  always_comb begin
    {cmp_lt, cmp_eq, cmp_gt} = 3'b000;
    if (!cmp_reset && ccnt >= LAT - 1)
      {cmp_lt, cmp_eq, cmp_gt} = force_en ? force_flags
                                          : {cmp_a < cmp_b, cmp_a == cmp_b, cmp_a > cmp_b};
  end

  function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {a < b, a == b, a > b};
  endfunction

  function automatic int exp_grant(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_accept(output bit got, output bit id);
    got = 1'b0;
    id  = 1'b0;
    #1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        id  = req1_ready;
      end else begin
        tick();
      end
    end
  endtask

  task automatic wait_result(input int start, output int edges);
    edges = start;
    while (!res_valid && edges < 400) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; res_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got=%b exp=0", busy); end
    checks++; if (cmp_reset !== 1'b1) begin errors++; $display("FAIL reset_cmp_reset: got=%b exp=1", cmp_reset); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got=%b exp=0", res_valid); end
    checks++; if ({cmp_a, cmp_b} !== 8'h00) begin errors++; $display("FAIL reset_operands: got=%h exp=00", {cmp_a, cmp_b}); end
    checks++; if ({res_id, res_lt, res_eq, res_gt} !== 4'b0000) begin errors++; $display("FAIL reset_res: got=%b exp=0000", {res_id, res_lt, res_eq, res_gt}); end
    reset = 1'b0;
    model_last = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit got, id; int edges;
    res_ready = 1; req0_a = 4'hA; req0_b = 4'hB; req0_valid = 1;
    wait_accept(got, id);
    checks++; if (!got || int'(id) != exp_grant(1, 0, model_last)) begin errors++; $display("FAIL single_grant: got=%b/%0d exp=1/0", got, id); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_req1_ready: got=%b exp=0", req1_ready); end
    tick(); req0_valid = 0; model_last = 0; #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_pulse: got=%b exp=0", req0_ready); end
    checks++; if (cmp_reset !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_clear: cmp_reset=%b busy=%b exp=1,1", cmp_reset, busy); end
    checks++; if ({cmp_a, cmp_b} !== 8'hAB) begin errors++; $display("FAIL single_operands: got=%h exp=ab", {cmp_a, cmp_b}); end
    tick();
    checks++; if (cmp_reset !== 1'b0) begin errors++; $display("FAIL single_wait_cmp_reset: got=%b exp=0", cmp_reset); end
    wait_result(1, edges);
    checks++; if (edges != LAT + 1) begin errors++; $display("FAIL single_latency: got=%0d exp=%0d", edges, LAT + 1); end
    checks++; if ({res_lt, res_eq, res_gt} !== ref_cmp(4'hA, 4'hB)) begin errors++; $display("FAIL single_flags: got=%b exp=%b", {res_lt, res_eq, res_gt}, ref_cmp(4'hA, 4'hB)); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL single_id: got=%b exp=0", res_id); end
    tick();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_one_cycle: res_valid=%b busy=%b exp=0,0", res_valid, busy); end
  endtask

  task automatic test_arbitration();
    bit got, id; int edges, e; logic [2:0] ef;
    reset = 1; tick(); reset = 0; model_last = 1;
    req0_a = 4'h8; req0_b = 4'h8; req1_a = 4'hF; req1_b = 4'h1;
    req0_valid = 1; req1_valid = 1; res_ready = 1;
    for (int t = 0; t < 6; t++) begin
      e = exp_grant(1, 1, model_last);
      wait_accept(got, id);
      checks++; if (!got || int'(id) != e) begin errors++; $display("FAIL arb_grant%0d: got=%b/%0d exp=1/%0d", t, got, id, e); end
      checks++; if ({req0_ready, req1_ready} !== ((e == 1) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL arb_ready%0d: got=%b", t, {req0_ready, req1_ready}); end
      tick(); model_last = e[0];
      wait_result(0, edges);
      ef = (e == 1) ? ref_cmp(4'hF, 4'h1) : ref_cmp(4'h8, 4'h8);
      checks++; if (edges != LAT + 1) begin errors++; $display("FAIL arb_latency%0d: got=%0d exp=%0d", t, edges, LAT + 1); end
      checks++; if ({res_id, res_lt, res_eq, res_gt} !== {e[0], ef}) begin errors++; $display("FAIL arb_result%0d: got=%b exp=%b", t, {res_id, res_lt, res_eq, res_gt}, {e[0], ef}); end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_stall();
    bit got, id; int edges, e;
    req0_a = 4'h3; req0_b = 4'h9; req0_valid = 1; res_ready = 0;
    wait_accept(got, id);
    checks++; if (!got || id !== 1'b0) begin errors++; $display("FAIL stall_grant: got=%b/%0d exp=1/0", got, id); end
    tick(); req0_valid = 0; model_last = 0;
    req1_a = 4'h6; req1_b = 4'h6; req1_valid = 1;
    wait_result(0, edges);
    checks++; if (edges != LAT + 1) begin errors++; $display("FAIL stall_latency: got=%0d exp=%0d", edges, LAT + 1); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({res_valid, res_id, res_lt, res_eq, res_gt, req0_ready, req1_ready} !== {2'b10, ref_cmp(4'h3, 4'h9), 2'b00}) begin
        errors++;
        $display("FAIL stall_hold%0d: got=%b exp=%b", i, {res_valid, res_id, res_lt, res_eq, res_gt, req0_ready, req1_ready}, {2'b10, ref_cmp(4'h3, 4'h9), 2'b00});
      end
    end
    res_ready = 1;
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got=%b exp=0", res_valid); end
    e = exp_grant(0, 1, model_last);
    wait_accept(got, id);
    checks++; if (!got || int'(id) != e) begin errors++; $display("FAIL stall_next_grant: got=%b/%0d exp=1/%0d", got, id, e); end
    tick(); req1_valid = 0; model_last = 1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_single_transfer: got=%b exp=0", res_valid); end
    wait_result(0, edges);
    checks++; if ({res_id, res_lt, res_eq, res_gt} !== {1'b1, ref_cmp(4'h6, 4'h6)}) begin errors++; $display("FAIL stall_next_result: got=%b exp=%b", {res_id, res_lt, res_eq, res_gt}, {1'b1, ref_cmp(4'h6, 4'h6)}); end
    tick();
  endtask

  task automatic test_abort();
    bit got, id, seen; int edges;
    req0_a = 4'h5; req0_b = 4'h2; req0_valid = 1; res_ready = 1;
    wait_accept(got, id);
    tick(); req0_valid = 0;
    tick(); tick(); tick();
    #2; reset = 1; #1;
    checks++; if ({busy, cmp_reset, res_valid} !== 3'b010) begin errors++; $display("FAIL abort_async_ctrl: got=%b exp=010", {busy, cmp_reset, res_valid}); end
    checks++; if ({cmp_a, cmp_b, res_id, res_lt, res_eq, res_gt} !== 12'h000) begin errors++; $display("FAIL abort_async_data: got=%h exp=000", {cmp_a, cmp_b, res_id, res_lt, res_eq, res_gt}); end
    tick(); reset = 0; model_last = 1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (res_valid) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_result: got=1 exp=0"); end
    req1_a = 4'h0; req1_b = 4'hF; req1_valid = 1;
    wait_accept(got, id);
    checks++; if (!got || id !== 1'b1) begin errors++; $display("FAIL abort_next_grant: got=%b/%0d exp=1/1", got, id); end
    tick(); req1_valid = 0; model_last = 1;
    wait_result(0, edges);
    checks++; if (edges != LAT + 1) begin errors++; $display("FAIL abort_next_latency: got=%0d exp=%0d", edges, LAT + 1); end
    checks++; if ({res_id, res_lt, res_eq, res_gt} !== {1'b1, ref_cmp(4'h0, 4'hF)}) begin errors++; $display("FAIL abort_next_result: got=%b exp=%b", {res_id, res_lt, res_eq, res_gt}, {1'b1, ref_cmp(4'h0, 4'hF)}); end
    tick();
  endtask

  task automatic test_passthrough();
    bit got, id; int edges;
    force_en = 1; force_flags = 3'b110;
    req0_a = 4'h1; req0_b = 4'h2; req0_valid = 1; res_ready = 1;
    wait_accept(got, id);
    tick(); req0_valid = 0; model_last = 0;
    wait_result(0, edges);
    checks++; if ({res_lt, res_eq, res_gt} !== 3'b110) begin errors++; $display("FAIL passthrough_flags: got=%b exp=110", {res_lt, res_eq, res_gt}); end
    tick();
    force_en = 0;
  endtask

  task automatic test_back_to_back();
    bit got, id; int edges, prev, e;
    logic [WIDTH-1:0] oa[6], ob[6];
    oa[0] = 4'h0; ob[0] = 4'h0; oa[1] = 4'hF; ob[1] = 4'h0;
    for (int k = 2; k < 6; k++) begin oa[k] = WIDTH'($urandom); ob[k] = WIDTH'($urandom); end
    req1_a = oa[0]; req1_b = ob[0]; req1_valid = 1; res_ready = 1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      e = exp_grant(0, 1, model_last);
      wait_accept(got, id);
      checks++; if (!got || int'(id) != e) begin errors++; $display("FAIL b2b_grant%0d: got=%b/%0d exp=1/%0d", k, got, id, e); end
      if (k > 0) begin
        checks++; if (cyc - prev != LAT + 3) begin errors++; $display("FAIL b2b_interval%0d: got=%0d exp=%0d", k, cyc - prev, LAT + 3); end
      end
      prev = cyc;
      tick(); model_last = 1;
      if (k < 5) begin req1_a = oa[k+1]; req1_b = ob[k+1]; end
      else req1_valid = 0;
      wait_result(0, edges);
      checks++; if ({res_id, res_lt, res_eq, res_gt} !== {1'b1, ref_cmp(oa[k], ob[k])}) begin errors++; $display("FAIL b2b_result%0d: got=%b exp=%b", k, {res_id, res_lt, res_eq, res_gt}, {1'b1, ref_cmp(oa[k], ob[k])}); end
      tick();
    end
  endtask

  task automatic test_random();
    bit got, id; int edges, e, stall;
    logic [WIDTH-1:0] ea, eb; logic [2:0] ef;
    req0_valid = 0; req1_valid = 0;
    for (int n = 0; n < 40; n++) begin
      if (!req0_valid) begin
        req0_valid = 1'($urandom_range(0, 1)); req0_a = WIDTH'($urandom);
        req0_b = ($urandom_range(0, 3) == 0) ? req0_a : WIDTH'($urandom);
      end
      if (!req1_valid) begin
        req1_valid = 1'($urandom_range(0, 1)); req1_a = WIDTH'($urandom);
        req1_b = ($urandom_range(0, 3) == 0) ? req1_a : WIDTH'($urandom);
      end
      if (!req0_valid && !req1_valid) req0_valid = 1;
      e  = exp_grant(req0_valid, req1_valid, model_last);
      ea = (e == 1) ? req1_a : req0_a;
      eb = (e == 1) ? req1_b : req0_b;
      ef = ref_cmp(ea, eb);
      stall = $urandom_range(0, 3);
      res_ready = (stall == 0);
      wait_accept(got, id);
      checks++; if (!got || int'(id) != e) begin errors++; $display("FAIL rand_grant%0d: got=%b/%0d exp=1/%0d", n, got, id, e); end
      tick();
      if (e == 1) req1_valid = 0; else req0_valid = 0;
      model_last = e[0];
      wait_result(0, edges);
      checks++; if (edges != LAT + 1) begin errors++; $display("FAIL rand_latency%0d: got=%0d exp=%0d", n, edges, LAT + 1); end
      checks++; if ({res_id, res_lt, res_eq, res_gt} !== {e[0], ef}) begin errors++; $display("FAIL rand_result%0d: got=%b exp=%b", n, {res_id, res_lt, res_eq, res_gt}, {e[0], ef}); end
      for (int s = 0; s < stall; s++) begin
        tick();
        checks++; if ({res_valid, res_id, res_lt, res_eq, res_gt} !== {1'b1, e[0], ef}) begin errors++; $display("FAIL rand_hold%0d: got=%b exp=%b", n, {res_valid, res_id, res_lt, res_eq, res_gt}, {1'b1, e[0], ef}); end
      end
      res_ready = 1;
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rand_release%0d: got=%b exp=0", n, res_valid); end
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_stall();
    test_abort();
    test_passthrough();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
